fnd_scan_controller: RTL and testbench

- Downstream display stage of the stopwatch/watch datapath.
- Takes the 24-bit packed time word selected by the watch/stopwatch mux and time-multiplexes it onto the 4-digit common-anode 7-segment display.
- Does BCD splitting, glitch-free per-frame snapshot, anti-ghost blanking and a 1 Hz decimal-point blink.

---
 rtl/fnd_pkg.sv | 52 +++++
 rtl/fnd_scan_controller_if.sv | 23 ++
 rtl/fnd_seg_decoder.sv | 35 +++
 rtl/fnd_scan_controller.sv | 121 ++++++++++++
 tb/tb_fnd_scan_controller.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller:
// segment codes, packed time-word layout and per-field range limits.
package fnd_pkg;

  // Active-low segment codes {dp, g..a}, dp off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int unsigned MSEC_LSB = 0;
  localparam int unsigned SEC_LSB  = 7;
  localparam int unsigned MIN_LSB  = 13;
  localparam int unsigned HOUR_LSB = 19;

  localparam int unsigned MSEC_W = 7;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  // Decimal point is lit for the first half of each second.
  localparam logic [MSEC_W-1:0] DP_MSEC_LIMIT = 7'd50;

  // Packed layout matches {hour[23:19], min[18:13], sec[12:7], msec[6:0]}.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_word_t;

  typedef enum logic [1:0] {
    SLOT_0 = 2'd0,
    SLOT_1 = 2'd1,
    SLOT_2 = 2'd2,
    SLOT_3 = 2'd3
  } slot_e;

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Time-word input and segment/digit output bundle of the display scan stage.
interface fnd_scan_controller_if;

  logic [23:0] fnd_in_data;
  logic        sel_display;
  logic [3:0]  fnd_digit;
  logic [7:0]  fnd_data;

  modport master (
    output fnd_in_data,
    output sel_display,
    input  fnd_digit,
    input  fnd_data
  );

  modport slave (
    input  fnd_in_data,
    input  sel_display,
    output fnd_digit,
    output fnd_data
  );

endinterface

// File: rtl/fnd_seg_decoder.sv
// Combinational 4-bit digit to active-low 7-segment (g..a) decoder with
// dash and blank overrides; the decimal point is handled by the caller.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    if (blank) begin
      seg = SEG_BLANK[6:0];
    end else if (dash) begin
      seg = SEG_DASH[6:0];
    end else begin
      case (value)
        4'd0:    seg = SEG_0[6:0];
        4'd1:    seg = SEG_1[6:0];
        4'd2:    seg = SEG_2[6:0];
        4'd3:    seg = SEG_3[6:0];
        4'd4:    seg = SEG_4[6:0];
        4'd5:    seg = SEG_5[6:0];
        4'd6:    seg = SEG_6[6:0];
        4'd7:    seg = SEG_7[6:0];
        4'd8:    seg = SEG_8[6:0];
        4'd9:    seg = SEG_9[6:0];
        default: seg = SEG_BLANK[6:0];
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode scan controller: per-frame snapshot, BCD split,
// anti-ghost blanking, dp blink. Optional macro FND_LEAD_ZERO_BLANK_EN.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLANK_CYC = 1_000    // must be < SCAN_DIV
) (
  input  logic                        clk,
  input  logic                        reset,
  fnd_scan_controller_if.slave        bus
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] prescaler;
  slot_e            scan_idx;
  time_word_t       snap;
  logic             snap_sel;
  logic [3:0]       fnd_digit_q;
  logic [7:0]       fnd_data_q;

  logic             slot_tick;
  logic [1:0]       idx_inc;
  logic [6:0]       field;
  logic             field_ok;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [3:0]       digit_val;
  logic             lead_blank;
  logic             dp_lit;
  logic [6:0]       seg;
  logic             in_blank;
  logic [3:0]       digit_nxt;
  logic [7:0]       data_nxt;

  assign slot_tick = (prescaler == CNT_LAST);
  assign idx_inc   = scan_idx + 2'd1;
  assign in_blank  = (prescaler < CNT_BLANK);

  // Snapshot is taken on the tick that starts slot 0, so all four digits of
  // a frame are decoded from the same time word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler   <= '0;
      scan_idx    <= SLOT_0;
      snap        <= '0;
      snap_sel    <= 1'b0;
      fnd_digit_q <= '1;
      fnd_data_q  <= '1;
    end else begin
      prescaler <= slot_tick ? '0 : prescaler + 1'b1;
      if (slot_tick) begin
        scan_idx <= slot_e'(idx_inc);
        if (scan_idx == SLOT_3) begin
          snap     <= time_word_t'(bus.fnd_in_data);
          snap_sel <= bus.sel_display;
        end
      end
      fnd_digit_q <= digit_nxt;
      fnd_data_q  <= data_nxt;
    end
  end

  // Upper slot bit picks the field pair's left field, lower bit picks tens.
  always_comb begin
    field    = '0;
    field_ok = 1'b1;
    case ({snap_sel, scan_idx[1]})
      2'b00: begin
        field    = snap.msec;
        field_ok = (snap.msec <= MSEC_MAX);
      end
      2'b01: begin
        field    = {1'b0, snap.sec};
        field_ok = (snap.sec <= SEC_MAX);
      end
      2'b10: begin
        field    = {1'b0, snap.min};
        field_ok = (snap.min <= MIN_MAX);
      end
      default: begin
        field    = {2'b00, snap.hour};
        field_ok = (snap.hour <= HOUR_MAX);
      end
    endcase
    tens      = 4'(field / 7'd10);
    ones      = 4'(field % 7'd10);
    digit_val = scan_idx[0] ? tens : ones;
  end

`ifdef FND_LEAD_ZERO_BLANK_EN
  assign lead_blank = (scan_idx == SLOT_3) && field_ok && (tens == 4'd0);
`else
  assign lead_blank = 1'b0;
`endif

  assign dp_lit = (scan_idx == SLOT_2) && (snap.msec < DP_MSEC_LIMIT);

  fnd_seg_decoder u_seg_decoder (
    .value (digit_val),
    .dash  (!field_ok),
    .blank (lead_blank),
    .seg   (seg)
  );

  always_comb begin
    digit_nxt = '1;
    data_nxt  = SEG_BLANK;
    if (!in_blank) begin
      digit_nxt = ~(4'b0001 << scan_idx);
      data_nxt  = {~dp_lit, seg};
    end
  end

  assign bus.fnd_digit = fnd_digit_q;
  assign bus.fnd_data  = fnd_data_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller with SCAN_DIV=8, BLANK_CYC=2.
module tb_fnd_scan_controller;

  localparam int DIV   = 8;
  localparam int FRAME = 4 * DIV;

  typedef struct {
    int         at_cyc;
    logic [3:0] dig;
    logic [7:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   ecnt;
  int   fi;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  bit   prev_en = 1'b0;
  exp_t exp_q[$];
  exp_t cur;

  fnd_scan_controller_if bus ();

  fnd_scan_controller #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  function automatic void chk(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, ecnt);
    end
  endfunction

  // Reference: what a person reading the display should see for one digit.
  function automatic logic [7:0] ref_seg(input logic [23:0] w, input bit sel, input int idx);
    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int hour, min, sec, msec, f, mx, d;
    logic [7:0] r;
    hour = int'(w[23:19]);
    min  = int'(w[18:13]);
    sec  = int'(w[12:7]);
    msec = int'(w[6:0]);
    if (idx < 2) begin f = sel ? min : msec;  mx = sel ? 59 : 99; end
    else         begin f = sel ? hour : sec;  mx = sel ? 23 : 59; end
    d = (idx % 2 == 0) ? f % 10 : f / 10;
    if (f > mx) r = 8'hBF;
    else begin
      r = tbl[d];
`ifdef FND_LEAD_ZERO_BLANK_EN
      if (idx == 3 && d == 0) r = 8'hFF;
`endif
    end
    if (idx == 2 && msec < 50) r[7] = 1'b0;
    return r;
  endfunction

  function automatic logic [23:0] mk(input int h, input int m, input int s, input int ms);
    return {5'(h), 6'(m), 6'(s), 7'(ms)};
  endfunction

  task automatic push_frame(input int base, input logic [23:0] w, input bit sel);
    exp_t e;
    logic [3:0] one;
    for (int s = 0; s < 4; s++) begin
      one      = 4'b0001;
      e.at_cyc = base + DIV * s + 3;
      e.dig    = ~(one << s);
      e.dat    = ref_seg(w, sel, s);
      exp_q.push_back(e);
    end
  endtask

  // Inputs wiggle randomly all frame; only the value present at the snapshot
  // edge matters, and it is changed again right after that edge.
  task automatic do_frame(input logic [23:0] w, input bit s);
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clk); #1;
      if (c == FRAME - 2) begin
        bus.fnd_in_data = w;
        bus.sel_display = s;
        push_frame(FRAME * (fi + 1), w, s);
      end else if (c == FRAME - 1 || $urandom_range(0, 3) == 0) begin
        bus.fnd_in_data = 24'($urandom);
        bus.sel_display = 1'($urandom);
      end
    end
    fi++;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("reset_digit_async", int'(bus.fnd_digit), 'hF);
    chk("reset_data_async", int'(bus.fnd_data), 'hFF);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      bus.fnd_in_data = 24'($urandom);
      bus.sel_display = 1'($urandom);
      @(negedge clk);
      chk("reset_digit", int'(bus.fnd_digit), 'hF);
      chk("reset_data", int'(bus.fnd_data), 'hFF);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    fi    = 0;
    push_frame(0, 24'h0, 1'b0);
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_en = 1'b0;
    end else if (mon_en) begin
      if (bus.fnd_digit == 4'hF) begin
        chk("blank_data", int'(bus.fnd_data), 'hFF);
        prev_en = 1'b0;
      end else if (!prev_en) begin
        prev_en = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_slot", int'(bus.fnd_digit), 'hF);
          cur.at_cyc = -1;
          cur.dig    = bus.fnd_digit;
          cur.dat    = bus.fnd_data;
        end else begin
          cur = exp_q.pop_front();
          chk("slot_timing", ecnt, cur.at_cyc);
          chk("slot_digit", int'(bus.fnd_digit), int'(cur.dig));
          chk("slot_data", int'(bus.fnd_data), int'(cur.dat));
        end
      end else begin
        chk("hold_digit", int'(bus.fnd_digit), int'(cur.dig));
        chk("hold_data", int'(bus.fnd_data), int'(cur.dat));
      end
    end
  end

  initial begin
    logic [23:0] dir_w [11];
    bit          dir_s [11];
    int          k;
    bus.fnd_in_data = 24'($urandom);
    bus.sel_display = 1'($urandom);
    dir_w = '{mk(12, 34, 56, 78), mk(12, 34, 56, 78), mk(0, 0, 0, 25),
              mk(0, 0, 0, 75),    mk(0, 0, 60, 78),   mk(5, 30, 0, 0),
              mk(0, 0, 59, 99),   mk(23, 59, 0, 0),   mk(24, 0, 0, 0),
              mk(0, 60, 0, 0),    mk(0, 0, 0, 100)};
    dir_s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    do_reset();
    for (int i = 0; i < 11; i++) do_frame(dir_w[i], dir_s[i]);
    for (int i = 0; i < 20; i++) do_frame(24'($urandom), 1'($urandom));

    // Abort a frame part-way through with an asynchronous reset.
    k = $urandom_range(5, 25);
    repeat (k) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 6; i++) do_frame(24'($urandom), 1'($urandom));

    for (int i = 0; i < 2 * FRAME && exp_q.size() > 0; i++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
